// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush sequencer for the 5-stage core (multi-cycle EX ops, exception redirect).
// Build macro STALL_WATCHDOG_EN adds the sticky PC-stall watchdog driving STALL_TIMEOUT.
module pipe_stall_ctrl #(
    parameter int CNT_W      = 6,
    parameter int ADDR_W     = 32,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IF_STALL_REQ,
    input  logic              ID_STALL_REQ,
    input  logic              EX_STALL_REQ,
    input  logic              MEM_STALL_REQ,
    input  logic              MC_START,
    input  logic [CNT_W-1:0]  MC_CYCLES,
    input  logic              EXCEPT_REQ,
    input  logic [ADDR_W-1:0] EXCEPT_PC,
    output logic [5:0]        STALL,
    output logic              FLUSH,
    output logic [ADDR_W-1:0] NEW_PC,
    output logic              MC_DONE,
    output logic              BUSY,
    output logic              STALL_TIMEOUT
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_MC    = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W-1:0] new_pc_q;
    logic [ADDR_W-1:0] new_pc_d;
    logic              flush_q;
    logic              busy_q;
    logic              mc_hold_s;
    logic              mc_done_s;
    logic [5:0]        stall_s;

    // Sequencer next state; an exception overrides everything, including a same-cycle MC_START.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        new_pc_d  = new_pc_q;
        mc_hold_s = 1'b0;
        mc_done_s = 1'b0;
        case (state_q)
            S_RUN: begin
                if (MC_START && !EXCEPT_REQ) begin
                    if (MC_CYCLES >= CNT_TWO) begin
                        mc_hold_s = 1'b1;
                        cnt_d     = MC_CYCLES - CNT_ONE;
                        state_d   = S_MC;
                    end else begin
                        mc_done_s = 1'b1;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_MC: begin
                // Counts down even under a MEM stall: EX occupancy is fixed by the op.
                if (cnt_q > CNT_ONE) begin
                    mc_hold_s = 1'b1;
                    cnt_d     = cnt_q - CNT_ONE;
                end else begin
                    mc_done_s = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_RUN;
                end
            end
            S_FLUSH: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
        endcase
        if (EXCEPT_REQ) begin
            new_pc_d = EXCEPT_PC;
            cnt_d    = '0;
            state_d  = S_FLUSH;
        end else begin
            new_pc_d = new_pc_q;
        end
    end

    // Priority merge of stall sources; the flush cycle releases every stage.
    always_comb begin
        stall_s = STALL_NONE;
        if (state_q == S_FLUSH) begin
            stall_s = STALL_NONE;
        end else if (MEM_STALL_REQ) begin
            stall_s = STALL_MEM;
        end else if (EX_STALL_REQ || mc_hold_s) begin
            stall_s = STALL_EX;
        end else if (ID_STALL_REQ) begin
            stall_s = STALL_ID;
        end else if (IF_STALL_REQ) begin
            stall_s = STALL_IF;
        end else begin
            stall_s = STALL_NONE;
        end
    end

    // Sequencer state, redirect target and registered status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_RUN;
            cnt_q    <= '0;
            new_pc_q <= '0;
            flush_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            new_pc_q <= new_pc_d;
            flush_q  <= EXCEPT_REQ;
            busy_q   <= (state_d != S_RUN);
        end
    end

    assign STALL   = stall_s;
    assign FLUSH   = flush_q;
    assign NEW_PC  = new_pc_q;
    assign BUSY    = busy_q;
    // A reset cycle must never report completion of an op it is aborting.
    assign MC_DONE = mc_done_s & ~RST;

`ifdef STALL_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);
    localparam logic [WDOG_W-1:0] WDOG_ONE = WDOG_W'(1);

    logic [WDOG_W-1:0] wdog_q;
    logic [WDOG_W-1:0] wdog_d;
    logic              timeout_q;
    logic              timeout_d;

    // Run length of consecutive PC stalls, saturating at the limit.
    always_comb begin
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        if (stall_s[0] && !flush_q) begin
            if (wdog_q != WDOG_MAX) begin
                wdog_d = wdog_q + WDOG_ONE;
            end else begin
                wdog_d = wdog_q;
            end
        end else begin
            wdog_d = '0;
        end
        if (wdog_d == WDOG_MAX) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign STALL_TIMEOUT = timeout_q;
`else
    assign STALL_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized scoreboard bench for pipe_stall_ctrl against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;

    localparam int WDOG = 8;

    logic        CLK;
    logic        RST;
    logic        IF_STALL_REQ;
    logic        ID_STALL_REQ;
    logic        EX_STALL_REQ;
    logic        MEM_STALL_REQ;
    logic        MC_START;
    logic [5:0]  MC_CYCLES;
    logic        EXCEPT_REQ;
    logic [31:0] EXCEPT_PC;
    logic [5:0]  STALL;
    logic        FLUSH;
    logic [31:0] NEW_PC;
    logic        MC_DONE;
    logic        BUSY;
    logic        STALL_TIMEOUT;

    pipe_stall_ctrl #(.CNT_W(6), .ADDR_W(32), .WDOG_LIMIT(WDOG)) dut (
        .CLK(CLK), .RST(RST),
        .IF_STALL_REQ(IF_STALL_REQ), .ID_STALL_REQ(ID_STALL_REQ),
        .EX_STALL_REQ(EX_STALL_REQ), .MEM_STALL_REQ(MEM_STALL_REQ),
        .MC_START(MC_START), .MC_CYCLES(MC_CYCLES),
        .EXCEPT_REQ(EXCEPT_REQ), .EXCEPT_PC(EXCEPT_PC),
        .STALL(STALL), .FLUSH(FLUSH), .NEW_PC(NEW_PC),
        .MC_DONE(MC_DONE), .BUSY(BUSY), .STALL_TIMEOUT(STALL_TIMEOUT)
    );

    typedef struct {
        int          cyc;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        done;
        logic        busy;
        logic        to;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc_no = 0;

    // Reference model state: remaining EX cycles of the current op (0 = none).
    int          mc_left = 0;
    bit          m_flush = 1'b0;
    logic [31:0] m_pc = 32'h0;
    int          wd_run = 0;
    bit          m_to = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc(input bit i_if, input bit i_id, input bit i_ex, input bit i_mem,
                       input bit i_mcs, input int i_mcc, input bit i_exc,
                       input logic [31:0] i_pc, input bit i_rst);
        exp_t e;
        int   lvl;
        bit   hold;
        bit   done;
        bit   start;
        @(negedge CLK);
        IF_STALL_REQ  = i_if;
        ID_STALL_REQ  = i_id;
        EX_STALL_REQ  = i_ex;
        MEM_STALL_REQ = i_mem;
        MC_START      = i_mcs;
        MC_CYCLES     = 6'(i_mcc);
        EXCEPT_REQ    = i_exc;
        EXCEPT_PC     = i_pc;
        RST           = i_rst;
        hold = 1'b0; done = 1'b0; start = 1'b0;
        if (!m_flush) begin
            if (mc_left > 0) begin
                hold = (mc_left > 1);
                done = (mc_left == 1);
            end else if (i_mcs && !i_exc) begin
                start = 1'b1;
                if (i_mcc <= 1) done = 1'b1;
                else hold = 1'b1;
            end
        end
        lvl = 0;
        if (i_if) lvl = 2;
        if (i_id) lvl = 3;
        if (i_ex || hold) lvl = 4;
        if (i_mem) lvl = 5;
        e.cyc   = cyc_no;
        e.stall = m_flush ? 6'd0 : 6'((1 << lvl) - 1);
        e.flush = m_flush;
        e.pc    = m_pc;
        e.done  = done && !i_rst;
        e.busy  = m_flush || (mc_left > 0);
        e.to    = m_to;
        sb_q.push_back(e);
        cyc_no++;
`ifdef STALL_WATCHDOG_EN
        if (e.stall[0]) wd_run++;
        else wd_run = 0;
        if (wd_run >= WDOG) m_to = 1'b1;
`endif
        if (i_rst) begin
            mc_left = 0; m_flush = 1'b0; m_pc = 32'h0; wd_run = 0; m_to = 1'b0;
        end else if (i_exc) begin
            m_flush = 1'b1; mc_left = 0; m_pc = i_pc;
        end else begin
            m_flush = 1'b0;
            if (mc_left > 0) mc_left--;
            else if (start && i_mcc >= 2) mc_left = i_mcc - 1;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #4;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                vectors++;
                if (STALL !== e.stall || FLUSH !== e.flush || NEW_PC !== e.pc ||
                    MC_DONE !== e.done || BUSY !== e.busy || STALL_TIMEOUT !== e.to) begin
                    miscompares++;
                    $display("FAIL outputs cyc=%0d got STALL=%b FLUSH=%b NEW_PC=%h MC_DONE=%b BUSY=%b TO=%b want STALL=%b FLUSH=%b NEW_PC=%h MC_DONE=%b BUSY=%b TO=%b",
                             e.cyc, STALL, FLUSH, NEW_PC, MC_DONE, BUSY, STALL_TIMEOUT,
                             e.stall, e.flush, e.pc, e.done, e.busy, e.to);
                end
            end
        end
    end

    initial begin
        RST = 1'b1;
        IF_STALL_REQ = 1'b0; ID_STALL_REQ = 1'b0; EX_STALL_REQ = 1'b0; MEM_STALL_REQ = 1'b0;
        MC_START = 1'b0; MC_CYCLES = 6'd0; EXCEPT_REQ = 1'b0; EXCEPT_PC = 32'h0;
        repeat (2) @(posedge CLK);
        idle(2);
        // Stall priority
        cyc(0, 1, 0, 0, 0, 0, 0, 32'h0, 0);
        cyc(0, 1, 0, 1, 0, 0, 0, 32'h0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 32'h0, 0);
        // Five-cycle op
        cyc(0, 0, 0, 0, 1, 5, 0, 32'h0, 0);
        idle(6);
        // Single-cycle and zero-length ops
        cyc(0, 0, 0, 0, 1, 1, 0, 32'h0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
        idle(2);
        // Exception during op cycle 2
        cyc(0, 0, 0, 0, 1, 5, 0, 32'h0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'hBFC00380, 0);
        idle(6);
        // Start and exception together, then back-to-back exceptions
        cyc(0, 0, 0, 0, 1, 4, 1, 32'h00001234, 0);
        idle(3);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'hAAAA0000, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h5555FFFC, 0);
        idle(3);
        // MEM stall during op still counts down
        cyc(0, 0, 0, 0, 1, 4, 0, 32'h0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 32'h0, 0);
        idle(3);
        // Reset in the middle of an op and of a flush
        cyc(0, 0, 0, 0, 1, 6, 0, 32'h0, 0);
        idle(2);
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
        idle(2);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0BAD0000, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
        idle(2);
        // Long MEM stall (watchdog limit crossing), then release
        for (int k = 0; k < 10; k++) cyc(0, 0, 0, 1, 0, 0, 0, 32'h0, 0);
        idle(3);
        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 5) == 0,
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 9)),
                $urandom_range(0, 24) == 0, $urandom, $urandom_range(0, 149) == 0);
        end
        idle(1);
        for (int k = 0; k < 5 && sb_q.size() != 0; k++) @(posedge CLK);
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
